// File: rtl/branch_unit_if.sv
// Valid/ready bundle between register read, the branch unit and the redirect/writeback consumer.
// The master modport is the producer/consumer side; the slave modport is the branch unit.
interface branch_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_next_pc;
  logic            out_mispredict;
  logic            out_misaligned;
  logic            out_illegal;

  modport master (
    output in_valid,
    output in_funct3,
    output in_rs1,
    output in_rs2,
    output in_pc,
    output in_imm,
    output in_pred_taken,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_taken,
    input  out_target,
    input  out_next_pc,
    input  out_mispredict,
    input  out_misaligned,
    input  out_illegal
  );

  modport slave (
    input  in_valid,
    input  in_funct3,
    input  in_rs1,
    input  in_rs2,
    input  in_pc,
    input  in_imm,
    input  in_pred_taken,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_taken,
    output out_target,
    output out_next_pc,
    output out_mispredict,
    output out_misaligned,
    output out_illegal
  );

endinterface

// File: rtl/branch_unit.sv
// RV32I/RV64I branch resolution stage: compare, target/next-PC, mispredict detection,
// one-entry registered output behind valid/ready, and a saturating mispredict counter.
module branch_unit #(
  parameter int unsigned XLEN  = 32,
  parameter bit          HAS_C = 1'b0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  branch_unit_if.slave     bus,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [XLEN-1:0]  PcStep = XLEN'(4);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // Output register
  logic             valid_q, valid_d;
  logic             taken_q;
  logic [XLEN-1:0]  target_q;
  logic [XLEN-1:0]  next_pc_q;
  logic             mispredict_q;
  logic             misaligned_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational resolution of the incoming entry
  logic             rs_eq;
  logic             rs_lt;
  logic             rs_ltu;
  logic             taken_d;
  logic             illegal_d;
  logic [XLEN-1:0]  target_d;
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  next_pc_d;
  logic             mispredict_d;
  logic             misaligned_d;

  logic             in_ready;
  logic             accept;
  logic             load;
  logic             deliver;

  // Handshake
  assign in_ready = rst & (~valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  // An entry accepted during a flush belongs to the squashed path.
  assign load     = accept & ~flush;
  assign deliver  = valid_q & bus.out_ready;

  // Compare
  always_comb begin
    rs_eq  = (bus.in_rs1 == bus.in_rs2);
    rs_lt  = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
    rs_ltu = (bus.in_rs1 < bus.in_rs2);
  end

  // Decode
  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (bus.in_funct3)
      F3Beq:   taken_d = rs_eq;
      F3Bne:   taken_d = ~rs_eq;
      F3Blt:   taken_d = rs_lt;
      F3Bge:   taken_d = ~rs_lt;
      F3Bltu:  taken_d = rs_ltu;
      F3Bgeu:  taken_d = ~rs_ltu;
      default: illegal_d = 1'b1;
    endcase
  end

  // Target, next PC and exception flags
  always_comb begin
    target_d     = bus.in_pc + bus.in_imm;
    seq_pc       = bus.in_pc + PcStep;
    next_pc_d    = taken_d ? target_d : seq_pc;
    mispredict_d = ~illegal_d & (taken_d ^ bus.in_pred_taken);
    if (HAS_C) begin
      misaligned_d = taken_d & target_d[0];
    end else begin
      misaligned_d = taken_d & (|target_d[1:0]);
    end
  end

  // Output valid next state
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Mispredict counter; a delivery coinciding with flush still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (deliver && mispredict_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      next_pc_q    <= '0;
      mispredict_q <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (load) begin
        taken_q      <= taken_d;
        target_q     <= target_d;
        next_pc_q    <= next_pc_d;
        mispredict_q <= mispredict_d;
        misaligned_q <= misaligned_d;
        illegal_q    <= illegal_d;
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = valid_q;
  assign bus.out_taken      = taken_q;
  assign bus.out_target     = target_q;
  assign bus.out_next_pc    = next_pc_q;
  assign bus.out_mispredict = mispredict_q;
  assign bus.out_misaligned = misaligned_q;
  assign bus.out_illegal    = illegal_q;
  assign mispredict_count   = cnt_q;

endmodule
